// File: rtl/omsp_spm_key_loader_pkg.sv
// Shared widths and helpers for the SPM key loader.
// The loader moves a derived key into the protected-module array 16 bits at a time.
package omsp_spm_key_loader_pkg;

    localparam int KEY_WORD_W = 16;
    localparam int TMO_W      = 10;

    // Number of 16-bit words that make up one key.
    function automatic int words_per_key(input int security);
        return security / KEY_WORD_W;
    endfunction

endpackage

// File: rtl/omsp_spm_key_loader.sv
// Key-transfer sequencer: accepts key words over valid/ready and issues one
// registered write_key strobe per word, aborting on violation or stalled source.
module omsp_spm_key_loader
    import omsp_spm_key_loader_pkg::*;
#(
    parameter int SECURITY     = 64,
    parameter int KEY_IDX_SIZE = 2,
    parameter int TIMEOUT      = 64
) (
    input  logic                    mclk,
    input  logic                    puc_rst,
    input  logic                    start,
    input  logic                    abort,
    input  logic                    word_valid,
    input  logic [KEY_WORD_W-1:0]   word_in,
    output logic                    word_ready,
    output logic                    write_key,
    output logic [KEY_WORD_W-1:0]   key_in,
    output logic [KEY_IDX_SIZE-1:0] key_idx,
    output logic                    busy,
    output logic                    done,
    output logic                    error
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [KEY_IDX_SIZE:0] LAST_CNT = (KEY_IDX_SIZE+1)'(words_per_key(SECURITY) - 1);
    localparam logic [TMO_W-1:0]      TMO_LAST = TMO_W'(TIMEOUT - 1);

    state_t                state_r;
    logic [KEY_IDX_SIZE:0] cnt_r;
    logic [TMO_W-1:0]      tmo_r;
    logic                  accept_s;

    // Ready and accept decode; the violation input must block acceptance in the same cycle.
    always_comb begin
        word_ready = 1'b0;
        if ((state_r == ST_LOAD) && !abort) begin
            word_ready = 1'b1;
        end else begin
            word_ready = 1'b0;
        end
        accept_s = word_ready && word_valid;
    end

    assign busy = (state_r != ST_IDLE);

    // Sequencer FSM, counters and registered outputs to SPM control.
    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            state_r   <= ST_IDLE;
            cnt_r     <= '0;
            tmo_r     <= '0;
            write_key <= 1'b0;
            key_in    <= '0;
            key_idx   <= '0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            write_key <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start && !abort) begin
                        state_r <= ST_LOAD;
                        cnt_r   <= '0;
                        tmo_r   <= '0;
                    end
                end
                ST_LOAD: begin
                    if (abort) begin
                        state_r <= ST_IDLE;
                        error   <= 1'b1;
                    end else if (accept_s) begin
                        // An accept on the final idle cycle takes priority over the timeout.
                        write_key <= 1'b1;
                        key_in    <= word_in;
                        key_idx   <= cnt_r[KEY_IDX_SIZE-1:0];
                        cnt_r     <= cnt_r + {{KEY_IDX_SIZE{1'b0}}, 1'b1};
                        tmo_r     <= '0;
                        if (cnt_r == LAST_CNT) begin
                            state_r <= ST_DONE;
                        end
                    end else if (tmo_r == TMO_LAST) begin
                        state_r <= ST_IDLE;
                        error   <= 1'b1;
                    end else begin
                        tmo_r <= tmo_r + {{(TMO_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    done    <= 1'b1;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_omsp_spm_key_loader.sv
// Self-checking bench for omsp_spm_key_loader: directed scenarios plus random
// traffic compared every cycle against a transaction-level reference model.
module tb_omsp_spm_key_loader;

    localparam int SECURITY = 64;
    localparam int KIS      = 2;
    localparam int TIMEOUT  = 8;
    localparam int NWORDS   = SECURITY / 16;

    logic           mclk;
    logic           puc_rst;
    logic           start;
    logic           abort;
    logic           word_valid;
    logic [15:0]    word_in;
    logic           word_ready;
    logic           write_key;
    logic [15:0]    key_in;
    logic [KIS-1:0] key_idx;
    logic           busy;
    logic           done;
    logic           error;

    int n_tests;
    int n_fail;

    // Reference model: phase of the current load and expected registered outputs.
    bit       m_loading;
    bit       m_finishing;
    int       m_words;
    int       m_idle;
    bit       e_wk;
    int       e_key;
    int       e_idx;
    bit       e_done;
    bit       e_err;
    int       n_done_seen;
    int       n_done_exp;

    omsp_spm_key_loader #(
        .SECURITY    (SECURITY),
        .KEY_IDX_SIZE(KIS),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .mclk      (mclk),
        .puc_rst   (puc_rst),
        .start     (start),
        .abort     (abort),
        .word_valid(word_valid),
        .word_in   (word_in),
        .word_ready(word_ready),
        .write_key (write_key),
        .key_in    (key_in),
        .key_idx   (key_idx),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_loading   = 1'b0;
        m_finishing = 1'b0;
        m_words     = 0;
        m_idle      = 0;
        e_wk        = 1'b0;
        e_key       = 0;
        e_idx       = 0;
        e_done      = 1'b0;
        e_err       = 1'b0;
    endtask

    // Called at a negedge; asynchronous reset must clear every output at once.
    task automatic do_reset();
        puc_rst    = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        word_valid = 1'b0;
        word_in    = 16'h0000;
        #1;
        model_clear();
        check_eq("rst_write_key",  {31'd0, write_key},  32'd0);
        check_eq("rst_key_in",     {16'd0, key_in},     32'd0);
        check_eq("rst_key_idx",    {30'd0, key_idx},    32'd0);
        check_eq("rst_busy",       {31'd0, busy},       32'd0);
        check_eq("rst_done",       {31'd0, done},       32'd0);
        check_eq("rst_error",      {31'd0, error},      32'd0);
        check_eq("rst_word_ready", {31'd0, word_ready}, 32'd0);
        @(posedge mclk);
        @(negedge mclk);
        puc_rst = 1'b0;
    endtask

    // One clock cycle: drive inputs, check ready, advance model, check registered outputs.
    task automatic step(input bit st, input bit ab, input bit vl, input logic [15:0] w);
        bit exp_ready;
        start      = st;
        abort      = ab;
        word_valid = vl;
        word_in    = w;
        #1;
        exp_ready = m_loading && !ab;
        check_eq("word_ready", {31'd0, word_ready}, {31'd0, exp_ready});

        e_wk   = 1'b0;
        e_done = 1'b0;
        e_err  = 1'b0;
        if (m_finishing) begin
            m_finishing = 1'b0;
            e_done      = 1'b1;
            n_done_exp++;
        end else if (m_loading) begin
            if (ab) begin
                m_loading = 1'b0;
                e_err     = 1'b1;
            end else if (vl) begin
                e_wk   = 1'b1;
                e_key  = int'(w);
                e_idx  = m_words;
                m_words++;
                m_idle = 0;
                if (m_words == NWORDS) begin
                    m_loading   = 1'b0;
                    m_finishing = 1'b1;
                end
            end else if (m_idle == TIMEOUT - 1) begin
                m_loading = 1'b0;
                e_err     = 1'b1;
            end else begin
                m_idle++;
            end
        end else if (st && !ab) begin
            m_loading = 1'b1;
            m_words   = 0;
            m_idle    = 0;
        end

        @(posedge mclk);
        @(negedge mclk);
        if (done === 1'b1) n_done_seen++;
        check_eq("write_key", {31'd0, write_key}, {31'd0, e_wk});
        check_eq("key_in",    {16'd0, key_in},    32'(e_key));
        check_eq("key_idx",   {30'd0, key_idx},   32'(e_idx));
        check_eq("busy",      {31'd0, busy},      {31'd0, (m_loading || m_finishing)});
        check_eq("done",      {31'd0, done},      {31'd0, e_done});
        check_eq("error",     {31'd0, error},     {31'd0, e_err});
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 16'h0000);
    endtask

    initial begin
        int vl_pct;
        n_tests     = 0;
        n_fail      = 0;
        n_done_seen = 0;
        n_done_exp  = 0;
        puc_rst     = 1'b1;
        start       = 1'b0;
        abort       = 1'b0;
        word_valid  = 1'b0;
        word_in     = 16'h0000;
        @(negedge mclk);
        do_reset();

        // Back-to-back load with valid held high.
        step(1'b1, 1'b0, 1'b1, 16'h1111);
        step(1'b0, 1'b0, 1'b1, 16'h1111);
        step(1'b0, 1'b0, 1'b1, 16'h2222);
        step(1'b0, 1'b0, 1'b1, 16'h3333);
        step(1'b0, 1'b0, 1'b1, 16'h4444);
        idle_cycles(3);

        // Stalled source: 5-cycle gaps complete, an 8-cycle gap times out.
        step(1'b1, 1'b0, 1'b0, 16'h0000);
        for (int k = 0; k < NWORDS; k++) begin
            idle_cycles(5);
            step(1'b0, 1'b0, 1'b1, 16'(16'hA000 + k));
        end
        idle_cycles(3);
        step(1'b1, 1'b0, 1'b0, 16'h0000);
        step(1'b0, 1'b0, 1'b1, 16'hB000);
        idle_cycles(TIMEOUT);
        for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 1'b1, 16'hBEEF);
        idle_cycles(2);

        // Abort together with the third word.
        step(1'b1, 1'b0, 1'b0, 16'h0000);
        step(1'b0, 1'b0, 1'b1, 16'hC001);
        step(1'b0, 1'b0, 1'b1, 16'hC002);
        step(1'b0, 1'b1, 1'b1, 16'hC003);
        step(1'b0, 1'b0, 1'b1, 16'hC004);
        step(1'b0, 1'b0, 1'b1, 16'hC005);

        // Start while busy and start with abort in idle are both ignored.
        step(1'b1, 1'b1, 1'b0, 16'h0000);
        step(1'b0, 1'b0, 1'b1, 16'hD000);
        step(1'b1, 1'b0, 1'b0, 16'h0000);
        step(1'b0, 1'b0, 1'b1, 16'hD001);
        step(1'b1, 1'b0, 1'b1, 16'hD002);
        step(1'b1, 1'b0, 1'b1, 16'hD003);
        step(1'b0, 1'b0, 1'b1, 16'hD004);
        step(1'b0, 1'b0, 1'b1, 16'hD005);
        step(1'b0, 1'b1, 1'b0, 16'h0000);
        idle_cycles(2);

        // Reset after the second write, then a fresh load from index 0.
        step(1'b1, 1'b0, 1'b0, 16'h0000);
        step(1'b0, 1'b0, 1'b1, 16'hE001);
        step(1'b0, 1'b0, 1'b1, 16'hE002);
        do_reset();
        step(1'b1, 1'b0, 1'b0, 16'h0000);
        for (int k = 0; k < NWORDS; k++) step(1'b0, 1'b0, 1'b1, 16'(16'hE100 + k));
        idle_cycles(3);

        // Accept exactly on the last idle cycle before timeout.
        step(1'b1, 1'b0, 1'b0, 16'h0000);
        idle_cycles(TIMEOUT - 1);
        step(1'b0, 1'b0, 1'b1, 16'hF001);
        idle_cycles(TIMEOUT - 1);
        step(1'b0, 1'b0, 1'b1, 16'hF002);
        step(1'b0, 1'b0, 1'b1, 16'hF003);
        step(1'b0, 1'b0, 1'b1, 16'hF004);
        idle_cycles(3);

        // Random traffic with varying source density.
        vl_pct = 100;
        for (int c = 0; c < 3000; c++) begin
            if ((c % 64) == 0) vl_pct = ($urandom_range(0, 2) == 0) ? 100 :
                                        ($urandom_range(0, 1) == 0) ? 50 : 8;
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 5) == 0,
                     $urandom_range(0, 39) == 0,
                     $urandom_range(1, 100) <= vl_pct,
                     16'($urandom));
            end
        end
        idle_cycles(3);
        check_eq("done_count", 32'(n_done_seen), 32'(n_done_exp));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
